// File: rtl/input_buffer_loader_pkg.sv
// Shared configuration for the activation input path: array geometry,
// activation word width, and the loader state encoding.
package input_buffer_loader_pkg;

  localparam int sys_rows     = 4;  // rows in the systolic array
  localparam int A_BITWIDTH   = 8;  // activation word width
  localparam int super_A_rows = 3;  // words per row in one tile

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } loader_state_t;

  // Width of a counter that spans 0..n-1 (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_buffer_loader.sv
// input_buffer_loader: de-interleaves one valid/ready activation stream
// round-robin into ROWS row-FIFO write ports (word k -> row k mod ROWS),
// counts one tile of ROWS*TILE_LEN words and raises tile_ready until the
// consumer acknowledges it. Per-row backpressure comes from full[].
//
// Optional build macro INPUT_LOADER_ZERO_PAD_EN: an early s_last enters a
// PAD state that fills the rest of the tile with zero words instead of
// closing the tile short.
module input_buffer_loader
  import input_buffer_loader_pkg::*;
#(
  parameter int ROWS     = sys_rows,     // must be at least 2
  parameter int DWIDTH   = A_BITWIDTH,
  parameter int TILE_LEN = super_A_rows
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_last,
  output logic [ROWS-1:0]   wr_en,
  output logic [DWIDTH-1:0] wr_data,
  input  logic [ROWS-1:0]   full,
  output logic              tile_ready,
  input  logic              tile_ack,
  output logic              busy,
  output logic              err
);

  localparam int RW = ptr_width(ROWS);
  localparam int CW = ptr_width(TILE_LEN);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(TILE_LEN - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_FILL = FILL;
`ifdef INPUT_LOADER_ZERO_PAD_EN
  localparam logic [1:0] S_PAD  = PAD;
`endif
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]      state;
  logic [RW-1:0]   row_ptr;
  logic [RW-1:0]   row_nxt;
  logic [CW-1:0]   col_cnt;
  logic [CW-1:0]   col_nxt;
  logic [ROWS-1:0] row_onehot;
  logic            row_full;
  logic            hs;
  logic            at_end;

  // Handshake, backpressure and next slot position, all from registered state.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    row_onehot          = '0;
    row_onehot[row_ptr] = 1'b1;
    row_full            = full[row_ptr];
    s_ready             = (state == S_FILL) && !row_full;
    hs                  = s_valid && s_ready;
    at_end              = (row_ptr == LAST_ROW) && (col_cnt == LAST_COL);
    row_nxt             = row_ptr + RW'(1);
    col_nxt             = col_cnt;
    if (row_ptr == LAST_ROW) begin
      row_nxt = '0;
      col_nxt = col_cnt + CW'(1);
    end
  end

  assign busy = (state == S_FILL)
`ifdef INPUT_LOADER_ZERO_PAD_EN
              || (state == S_PAD)
`endif
              ;

  // Loader FSM, slot counters, registered write port and status flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state      <= S_IDLE;
      row_ptr    <= '0;
      col_cnt    <= '0;
      wr_en      <= '0;
      wr_data    <= '0;
      tile_ready <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless a slot is written below.
      wr_en <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FILL;
            row_ptr <= '0;
            col_cnt <= '0;
          end
        end

        S_FILL: begin
          if (hs) begin
            wr_en   <= row_onehot;
            wr_data <= s_data;
            row_ptr <= row_nxt;
            col_cnt <= col_nxt;
            if (at_end) begin
              state      <= S_DONE;
              tile_ready <= 1'b1;
              if (!s_last) err <= 1'b1;
            end else if (s_last) begin
              err <= 1'b1;
`ifdef INPUT_LOADER_ZERO_PAD_EN
              state <= S_PAD;
`else
              state      <= S_DONE;
              tile_ready <= 1'b1;
`endif
            end
          end
        end

`ifdef INPUT_LOADER_ZERO_PAD_EN
        S_PAD: begin
          if (!row_full) begin
            wr_en   <= row_onehot;
            wr_data <= '0;
            row_ptr <= row_nxt;
            col_cnt <= col_nxt;
            if (at_end) begin
              state      <= S_DONE;
              tile_ready <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          // tile_ack takes priority; a simultaneous start is simply not seen.
          if (tile_ack) begin
            state      <= S_IDLE;
            tile_ready <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer_loader.sv
// Self-checking bench for input_buffer_loader (ROWS=4, TILE_LEN=3, DWIDTH=8).
// Honours INPUT_LOADER_ZERO_PAD_EN the same way as the design.
module tb_input_buffer_loader;

  localparam int ROWS     = 4;
  localparam int TILE_LEN = 3;
  localparam int DWIDTH   = 8;
  localparam int N        = ROWS * TILE_LEN;

`ifdef INPUT_LOADER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_FILL = 1;
  localparam int P_PAD  = 2;
  localparam int P_DONE = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] s_data;
  logic              s_last;
  logic [ROWS-1:0]   wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic [ROWS-1:0]   full;
  logic              tile_ready;
  logic              tile_ack;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  // Reference model: tile progress as a flat count of filled slots.
  int              m_phase   = P_IDLE;
  int              m_k       = 0;
  bit              m_err     = 1'b0;
  logic [ROWS-1:0] m_wr_en   = '0;
  logic [7:0]      m_wr_data = '0;

  input_buffer_loader #(
    .ROWS    (ROWS),
    .DWIDTH  (DWIDTH),
    .TILE_LEN(TILE_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .tile_ready(tile_ready),
    .tile_ack  (tile_ack),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One clock of stimulus: drive at the falling edge, compare outputs against
  // the model, then advance the model across the next rising edge.
  task automatic cycle(input bit st, input bit v, input logic [7:0] d, input bit l,
                       input logic [ROWS-1:0] f, input bit ack);
    bit              exp_ready;
    logic [ROWS-1:0] nxt_en;
    @(negedge clk);
    start = st; s_valid = v; s_data = d; s_last = l; full = f; tile_ack = ack;
    #1;
    exp_ready = (m_phase == P_FILL) && !f[m_k % ROWS];
    check("s_ready", s_ready, exp_ready);
    check("wr_en", wr_en, m_wr_en);
    if (m_wr_en != '0) check("wr_data", wr_data, m_wr_data);
    check("tile_ready", tile_ready, m_phase == P_DONE);
    check("busy", busy, (m_phase == P_FILL) || (m_phase == P_PAD));
    check("err", err, m_err);
    if (wr_en != '0) n_writes++;
    nxt_en = '0;
    case (m_phase)
      P_IDLE: if (st) begin m_phase = P_FILL; m_k = 0; end
      P_FILL: if (v && exp_ready) begin
        nxt_en    = 4'b0001 << (m_k % ROWS);
        m_wr_data = d;
        m_k++;
        if (m_k == N) begin
          m_phase = P_DONE;
          if (!l) m_err = 1'b1;
        end else if (l) begin
          m_err   = 1'b1;
          m_phase = PAD_EN ? P_PAD : P_DONE;
        end
      end
      P_PAD: if (!f[m_k % ROWS]) begin
        nxt_en    = 4'b0001 << (m_k % ROWS);
        m_wr_data = '0;
        m_k++;
        if (m_k == N) m_phase = P_DONE;
      end
      P_DONE: if (ack) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    m_wr_en = nxt_en;
  endtask

  task automatic feed(input int from, input int to, input int last_at);
    for (int k = from; k <= to; k++) cycle(1'b0, 1'b1, 8'(k), k == last_at, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
  endtask

  task automatic close_tile();
    idle(1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b1);
    idle(1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wr_en"}, wr_en, '0);
    check({tag, "_wr_data"}, wr_data, '0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_tile_ready"}, tile_ready, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Mid-tile reset: the write already on the port is still seen, then nothing.
  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; s_valid = 1'b1; s_last = 1'b0; tile_ack = 1'b0; full = '0;
    #1;
    check("rst_inflight_wr_en", wr_en, m_wr_en);
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    m_phase = P_IDLE; m_k = 0; m_err = 1'b0; m_wr_en = '0; m_wr_data = '0;
  endtask

  typedef struct {
    bit              st;
    bit              v;
    logic [7:0]      d;
    bit              l;
    bit              ack;
    bit              e_ready;
    logic [ROWS-1:0] e_wr_en;
    logic [7:0]      e_wr_data;
    bit              e_tr;
    bit              e_busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit              v;
    bit              l;
    logic [ROWS-1:0] f;
    int              budget;

    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    full = '0; tile_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b1;

    // Basic tile: 12 back-to-back words 0x01..0x0C, s_last on 0x0C.
    for (int i = 0; i < 16; i++) tbl[i] = '{default: '0};
    tbl[0].st = 1'b1;
    for (int k = 1; k <= N; k++) begin
      tbl[k].v         = 1'b1;
      tbl[k].d         = 8'(k);
      tbl[k].l         = (k == N);
      tbl[k].e_ready   = 1'b1;
      tbl[k].e_busy    = 1'b1;
      tbl[k].e_wr_en   = (k >= 2) ? 4'(1 << ((k - 2) % ROWS)) : 4'b0000;
      tbl[k].e_wr_data = 8'(k - 1);
    end
    tbl[13].e_wr_en   = 4'b1000;
    tbl[13].e_wr_data = 8'h0C;
    tbl[13].e_tr      = 1'b1;
    tbl[14].ack       = 1'b1;
    tbl[14].e_tr      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = tbl[i].st; s_valid = tbl[i].v; s_data = tbl[i].d;
      s_last = tbl[i].l; tile_ack = tbl[i].ack; full = '0;
      #1;
      check("tbl_s_ready", s_ready, tbl[i].e_ready);
      check("tbl_wr_en", wr_en, tbl[i].e_wr_en);
      if (tbl[i].e_wr_en != '0) check("tbl_wr_data", wr_data, tbl[i].e_wr_data);
      check("tbl_tile_ready", tile_ready, tbl[i].e_tr);
      check("tbl_busy", busy, tbl[i].e_busy);
      check("tbl_err", err, 1'b0);
    end

    // Row 1 full for 5 cycles while word 2 is offered.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
    feed(1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h02, 1'b0, 4'b0010, 1'b0);
    feed(2, N, N);
    close_tile();

    // Words offered in IDLE are ignored; a second start in FILL is ignored.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hEE, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 8'hEF, 1'b0, '0, 1'b0);
    feed(1, 4, 0);
    cycle(1'b1, 1'b1, 8'h05, 1'b0, '0, 1'b0);
    feed(6, N, N);
    close_tile();

    // Early s_last on word 7.
    n_writes = 0;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
    feed(1, 7, 7);
    idle(8);
    check("early_last_write_count", n_writes, PAD_EN ? N : 7);
    check("early_last_err", err, 1'b1);
    close_tile();

    // Reset after word 6, then a fresh tile must start at row 0.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
    feed(1, 6, 0);
    reset_cycle();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
    feed(8'hA1, 8'hA1 + N - 1, 8'hA1 + N - 1);
    idle(1);

    // In DONE, start and tile_ack together: back to IDLE, nothing armed.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 8'h33, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 8'h34, 1'b0, '0, 1'b0);

    // Randomized tiles with random backpressure and the occasional early s_last.
    for (int t = 0; t < 15; t++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
      budget = 0;
      while (m_phase != P_DONE && budget < 500) begin
        v = ($urandom_range(0, 9) < 7);
        f = 4'($urandom) & 4'($urandom);
        l = (m_k == N - 1) ? 1'b1 : ($urandom_range(0, 49) == 0);
        cycle(1'b0, v, 8'($urandom), l, f, 1'b0);
        budget++;
      end
      if (m_phase != P_DONE) check("random_tile_timeout", tile_ready, 1'b1);
      idle($urandom_range(1, 3));
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'($urandom), 1'b1);
      idle(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_buffer_loader.md
Name: input_buffer_loader

Overview:
- Upstream neighbour of the per-row activation FIFOs that feed the systolic array rows.
- Accepts one valid/ready stream of activation words and de-interleaves it round-robin into ROWS FIFO write ports: word k goes to row k mod ROWS.
- Counts one tile of ROWS*TILE_LEN words, then flags the tile ready for the read-side sequencer.
- Applies per-row backpressure from each FIFO's full flag.

Parameters:
- ROWS, default sys_rows: number of row FIFOs. Must be at least 2.
- DWIDTH, default A_BITWIDTH: activation word width.
- TILE_LEN, default super_A_rows: words written to each row per tile.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- start  in  1  one-cycle pulse; arms loading of one tile.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  DWIDTH  input activation word.
- s_last  in  1  marks the final word of the tile on the input side.
- wr_en  out  ROWS  one-hot FIFO write strobe.
- wr_data  out  DWIDTH  write data, shared by all rows.
- full  in  ROWS  per-row FIFO full flags.
- tile_ready  out  1  level; the tile is completely written.
- tile_ack  in  1  pulse from the consumer; releases tile_ready.
- busy  out  1  high in FILL and PAD.
- err  out  1  sticky s_last mismatch flag.

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - state=IDLE, row_ptr=0, col_cnt=0;
  - wr_en=0, wr_data=0;
  - tile_ready=0, err=0.
  - s_ready is 0 while in IDLE.
- States: IDLE, FILL, PAD (present only with the optional feature), DONE.
- IDLE:
  - start=1 moves to FILL and clears row_ptr and col_cnt.
  - Words presented while in IDLE are not accepted.
- FILL:
  - s_ready = !full[row_ptr]. This is combinational from the registered row_ptr and the full input.
  - On a handshake, the next cycle has wr_en = one-hot(row_ptr) and wr_data = s_data. Latency is exactly 1 cycle.
  - Without a handshake, wr_en=0 on the next cycle.
  - After each handshake row_ptr increments and wraps at ROWS-1 to 0. col_cnt increments on that wrap.
- Final word:
  - Final word = handshake with row_ptr==ROWS-1 && col_cnt==TILE_LEN-1.
  - The final word moves to DONE and sets tile_ready on the cycle its write is issued.
  - If s_last is not asserted on the final word, set err=1 and still go to DONE.
- Early s_last: s_last on any other handshake sets err=1.
  - Without the optional feature, go to DONE.
  - With it, go to PAD.
- DONE:
  - tile_ready=1 and s_ready=0.
  - tile_ack=1 clears tile_ready and goes to IDLE.
  - tile_ack in any other state is ignored.
- start while busy or in DONE is ignored.
- start and tile_ack in the same cycle in DONE: tile_ack wins and moves to IDLE; start is dropped.
- ROWS>=2 guarantees that the write in flight never targets the row currently being tested for full.
- rst low mid-tile aborts immediately:
  - the write already issued completes;
  - no further wr_en pulses;
  - FIFO contents are the FIFOs' own concern.
- err clears only on reset.

Optional Feature:
- Macro: INPUT_LOADER_ZERO_PAD_EN.
- Enabled: an early s_last enters PAD.
  - PAD writes wr_data=0 to row_ptr each cycle that !full[row_ptr], advancing the counters exactly as in FILL.
  - s_ready=0 in PAD.
  - The pad that fills the final slot goes to DONE.
  - err is still set.
- Disabled: PAD does not exist; an early s_last goes straight to DONE with the tile short.

Decomposition:
- Config package holds sys_rows, A_BITWIDTH and super_A_rows; this block reuses them.
- Also add to Config: the state enum loader_state_t {IDLE, FILL, PAD, DONE}.
- No sub-module. The row_ptr/col_cnt counter pair is inline logic.

Test Plan (ROWS=4, TILE_LEN=3, DWIDTH=8):
- start, then 12 back-to-back words 0x01..0x0C with s_last on 0x0C:
  - wr_en sequence 0001,0010,0100,1000 repeated 3 times;
  - row 2 receives 0x03,0x07,0x0B;
  - tile_ready rises the cycle after 0x0C is accepted;
  - err=0.
- full[1]=1 for 5 cycles during word 2:
  - s_ready=0 for those 5 cycles;
  - no wr_en pulse;
  - then 0x02 is written to row 1;
  - order is otherwise unchanged.
- s_valid before start, and start during FILL:
  - no writes while IDLE;
  - the second start has no effect;
  - the tile still ends after 12 words.
- s_last on word 7:
  - err=1;
  - with INPUT_LOADER_ZERO_PAD_EN: 5 zero writes to rows 3,0,1,2,3, then tile_ready;
  - without it: tile_ready the cycle after word 7 is written, no further writes.
- rst=0 after word 6:
  - next cycle wr_en=0, s_ready=0, tile_ready=0;
  - a new start reloads from row 0.
- In DONE, start and tile_ack in the same cycle:
  - IDLE, tile_ready=0;
  - no new tile is armed.
